// File: rtl/dsm_dac_core.sv
// dsm_dac_core: order-1/2 delta-sigma DAC modulator with staged input.
// Define DSM_DITHER_EN to add 1-LSB LFSR dither to the input code.
module dsm_dac_core #(
  parameter int DATA_WIDTH = 4,
  parameter int ORDER      = 1,
  parameter int ACC_GUARD  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sample,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_ovl_clr,
  output logic                  o_dac_out,
  output logic                  o_overload
);
  localparam int W     = DATA_WIDTH;
  localparam int ACC_W = W + ACC_GUARD;
  localparam int SUM_W = ACC_W + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  localparam sum_t SAT_HI = sum_t'((1 << (ACC_W-1)) - 1);
  localparam sum_t SAT_LO = sum_t'(-(1 << (ACC_W-1)));
  localparam sum_t FB_ONE = sum_t'(1 << W);

  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("dsm_dac_core: ORDER must be 1 or 2");
  end
  if (ACC_GUARD < 0 || ACC_GUARD > 8) begin : g_bad_guard
    $error("dsm_dac_core: ACC_GUARD must be 0..8");
  end

  function automatic acc_t sat(input sum_t v);
    if (v > SAT_HI) return acc_t'(SAT_HI);
    if (v < SAT_LO) return acc_t'(SAT_LO);
    return acc_t'(v);
  endfunction

  function automatic logic over(input sum_t v);
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  function automatic logic pos(input acc_t v);
    return !v[ACC_W-1] && (|v);
  endfunction

  acc_t         i1_q, i2_q, i1_n, i2_n;
  logic [W-1:0] active_q, staged_q;
  logic         pend_q, dac_q, ovl_q;
  logic [W:0]   x;
  logic         y, hit;
  sum_t         fb, s1, s2;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      lfsr_q <= 16'hACE1;
    else if (i_sample)
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};
  end

  assign x = {1'b0, active_q} + {{W{1'b0}}, lfsr_q[0]};
`else
  assign x = {1'b0, active_q};
`endif

  assign y    = (ORDER == 2) ? pos(i2_q) : pos(i1_q);
  assign fb   = y ? FB_ONE : '0;
  assign s1   = sum_t'(i1_q) + sum_t'(x) - fb;
  assign i1_n = sat(s1);
  // second stage integrates the already-clamped first stage
  assign s2   = sum_t'(i2_q) + sum_t'(i1_n) - fb;
  assign i2_n = (ORDER == 2) ? sat(s2) : '0;
  assign hit  = i_sample &&
                (over(s1) || ((ORDER == 2) && over(s2)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i1_q  <= '0;
      i2_q  <= '0;
      dac_q <= 1'b0;
    end else if (i_sample) begin
      i1_q  <= i1_n;
      i2_q  <= i2_n;
      dac_q <= y;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_q <= '0;
      staged_q <= '0;
      pend_q   <= 1'b0;
    end else if (i_sample && pend_q) begin
      active_q <= staged_q;
      pend_q   <= 1'b0;
    end else if (i_valid && !pend_q) begin
      staged_q <= i_data;
      pend_q   <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ovl_q <= 1'b0;
    else if (hit)
      ovl_q <= 1'b1;
    else if (i_ovl_clr)
      ovl_q <= 1'b0;
  end

  assign o_ready    = !pend_q;
  assign o_dac_out  = dac_q;
  assign o_overload = ovl_q;
endmodule

// File: tb/tb_dsm_dac_core.sv
// tb_dsm_dac_core: scoreboard bench for dsm_dac_core.
// Three instances: order 1, order 2, order 1 with no guard bits.
module tb_dsm_dac_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] data = '0;
  logic       ovl_clr = 1'b0;
  logic [2:0] rdy, dac, ovl;

  always #5 clk = ~clk;

  dsm_dac_core #(.DATA_WIDTH(4), .ORDER(1), .ACC_GUARD(4)) u_o1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample),
    .i_valid(valid), .i_data(data), .o_ready(rdy[0]),
    .i_ovl_clr(ovl_clr), .o_dac_out(dac[0]),
    .o_overload(ovl[0]));

  dsm_dac_core #(.DATA_WIDTH(4), .ORDER(2), .ACC_GUARD(4)) u_o2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample),
    .i_valid(valid), .i_data(data), .o_ready(rdy[1]),
    .i_ovl_clr(ovl_clr), .o_dac_out(dac[1]),
    .o_overload(ovl[1]));

  dsm_dac_core #(.DATA_WIDTH(4), .ORDER(1), .ACC_GUARD(0)) u_g0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample(sample),
    .i_valid(valid), .i_data(data), .o_ready(rdy[2]),
    .i_ovl_clr(ovl_clr), .o_dac_out(dac[2]),
    .o_overload(ovl[2]));

  typedef struct {
    bit [2:0] rdy;
    bit [2:0] dac;
    bit [2:0] ovl;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  int ord[3] = '{1, 2, 1};
  int aw[3]  = '{8, 8, 4};
  int m_i1[3], m_i2[3];
  bit m_dac[3], m_ovl[3];
  bit m_pend;
  int m_act, m_stg;
  bit [15:0] m_lfsr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_i1[k] = 0; m_i2[k] = 0; m_dac[k] = 0; m_ovl[k] = 0;
    end
    m_pend = 0; m_act = 0; m_stg = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_dac"}, int'(dac[k]), 0);
      chk({tag, "_ovl"}, int'(ovl[k]), 0);
      chk({tag, "_rdy"}, int'(rdy[k]), 1);
    end
  endtask

  // one clock: drive, advance model, push, then pop and compare
  task automatic step(input bit smp, input bit vld,
                      input int dat, input bit clr);
    exp_t e;
    bit   acc, y, hit;
    int   x, fbv, n1, n2, lo, hi;
    @(negedge clk);
    sample = smp; valid = vld; data = 4'(dat); ovl_clr = clr;
    acc = vld && !m_pend;
    x = m_act;
`ifdef DSM_DITHER_EN
    x = x + int'(m_lfsr[0]);
`endif
    for (int k = 0; k < 3; k++) begin
      y = (ord[k] == 2) ? (m_i2[k] > 0) : (m_i1[k] > 0);
      hi = (1 << (aw[k] - 1)) - 1;
      lo = -(1 << (aw[k] - 1));
      hit = 0;
      if (smp) begin
        fbv = y ? 16 : 0;
        n1 = m_i1[k] + x - fbv;
        if (n1 > hi) begin n1 = hi; hit = 1; end
        if (n1 < lo) begin n1 = lo; hit = 1; end
        n2 = 0;
        if (ord[k] == 2) begin
          n2 = m_i2[k] + n1 - fbv;
          if (n2 > hi) begin n2 = hi; hit = 1; end
          if (n2 < lo) begin n2 = lo; hit = 1; end
        end
        m_i1[k] = n1; m_i2[k] = n2; m_dac[k] = y;
      end
      if (hit) m_ovl[k] = 1;
      else if (clr) m_ovl[k] = 0;
    end
    if (smp && m_pend) begin m_act = m_stg; m_pend = 0; end
    else if (acc) begin m_stg = dat; m_pend = 1; end
`ifdef DSM_DITHER_EN
    if (smp)
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                m_lfsr[15:1]};
`endif
    for (int k = 0; k < 3; k++) begin
      e.rdy[k] = !m_pend; e.dac[k] = m_dac[k]; e.ovl[k] = m_ovl[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sb_rdy%0d", k), int'(rdy[k]), int'(e.rdy[k]));
      chk($sformatf("sb_dac%0d", k), int'(dac[k]), int'(e.dac[k]));
      chk($sformatf("sb_ovl%0d", k), int'(ovl[k]), int'(e.ovl[k]));
    end
  endtask

  initial begin
    int ones1, ones2, win;
    m_reset();
    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // code 8: order 1 alternates, order 2 averages one half
    step(0, 1, 8, 0);
    step(1, 0, 0, 0);
    ones1 = 0; ones2 = 0;
    for (int t = 0; t < 256; t++) begin
      step(1, 0, 0, 0);
      if (t < 64) begin
        ones1 += int'(dac[0]);
`ifndef DSM_DITHER_EN
        chk("t1_pat", int'(dac[0]), t % 2);
`endif
      end
      ones2 += int'(dac[1]);
    end
`ifndef DSM_DITHER_EN
    chk("t1_den", ones1, 32);
    chk("t4_den", int'(ones2 >= 126 && ones2 <= 130), 1);
`endif
    chk("t4_ovl", int'(ovl[1]), 0);

    // handshake: 3 accepted, 9 waits for the next tick
    step(0, 1, 3, 0);
    chk("t3_rdy_lo", int'(rdy[0]), 0);
    for (int t = 0; t < 3; t++) begin
      step(0, 1, 9, 0);
      chk("t3_rdy_hold", int'(rdy[0]), 0);
    end
    step(1, 1, 9, 0);
    chk("t3_rdy_tick", int'(rdy[0]), 1);
    step(0, 1, 9, 0);
    chk("t3_rdy_acc9", int'(rdy[0]), 0);
    for (int t = 0; t < 8; t++) step(1, 0, 0, 0);

    // code 15: 15 ones in every 16-tick window once settled
    step(0, 1, 15, 0);
    step(1, 0, 0, 0);
    for (int t = 0; t < 32; t++) step(1, 0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      win = 0;
      for (int t = 0; t < 16; t++) begin
        step(1, 0, 0, 0);
        win += int'(dac[0]);
      end
`ifndef DSM_DITHER_EN
      chk("t2_win", win, 15);
`endif
    end

    // async reset with a word pending
    step(0, 1, 5, 0);
    chk("t6_pend", int'(rdy[0]), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    m_reset();
    @(negedge clk);
    sample = 0; valid = 0; ovl_clr = 0;
    rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step(1, 0, 0, 0);
`ifndef DSM_DITHER_EN
      chk("t2_zero", int'(dac[0]), 0);
`endif
    end

    // no guard bits: code 15 saturates, set beats clear
    step(0, 1, 15, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
`ifndef DSM_DITHER_EN
    chk("t5_set", int'(ovl[2]), 1);
`endif
    step(0, 0, 0, 1);
    chk("t5_clr", int'(ovl[2]), 0);
    for (int t = 0; t < 7; t++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
`ifndef DSM_DITHER_EN
    chk("t5_setwin", int'(ovl[2]), 1);
`endif
    step(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
